// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped 8N1 UART transmitter with a byte FIFO and registered bus reads
module uart_tx_periph #(
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_i,
  input  logic [3:0]  we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        tx_o,
  output logic        irq_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [15:0] div, fdiv, timer;
  logic [2:0] idx;
  logic [7:0] shift;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rp, wp;
  logic [AW:0] count;
  logic ovf, irq_en, empty, full, tick, pop, push_req, push, wr, rd, busy;
  logic [7:0] cnt8;
  logic [31:0] rdata;
  logic unused;
  assign unused = ^{addr_i[31:4], addr_i[1:0], data_i[31:16]};
  assign wr = enable_i && we_i != 4'd0;
  assign rd = enable_i && we_i == 4'd0;
  assign empty = count == '0;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign tick = timer == 16'd0;
  assign busy = state != IDLE;
  assign push_req = wr && addr_i[3:2] == 2'd0;
  assign push = push_req && (!full || pop);
  assign cnt8 = 8'(count);
  always_comb begin
    state_n = state;
    pop = 1'b0;
    case (state)
      IDLE: begin
        pop = !empty;
        state_n = empty ? IDLE : START;
      end
      START: state_n = tick ? DATA : START;
      DATA: state_n = (tick && idx == 3'd7) ? STOP : DATA;
      STOP: begin
        pop = tick && !empty;
        state_n = !tick ? STOP : empty ? IDLE : START;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // tx_o is registered from the state, so the line lags the FSM by one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_o <= 1'b1;
      timer <= '0;
      fdiv <= 16'd1;
      idx <= '0;
      shift <= '0;
    end else begin
      tx_o <= state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
      if (pop) begin
        shift <= mem[rp];
        fdiv <= div;
        timer <= div - 16'd1;
      end else if (busy) begin
        if (tick) begin
          timer <= fdiv - 16'd1;
          if (state == DATA) begin
            shift <= shift >> 1;
            idx <= idx + 3'd1;
          end
          if (state == START) idx <= '0;
        end else begin
          timer <= timer - 16'd1;
        end
      end
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wp] <= data_i[7:0];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
      ovf <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (push_req && full && !pop) ovf <= 1'b1;
      else if (wr && addr_i[3:2] == 2'd1 && data_i[3]) ovf <= 1'b0;
    end
  end
  always_comb
    rdata = addr_i[3:2] == 2'd1 ? {16'd0, cnt8, 4'd0, ovf, busy, full, empty} :
            addr_i[3:2] == 2'd2 ? {16'd0, div} :
            addr_i[3:2] == 2'd3 ? {31'd0, irq_en} : 32'd0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= 16'(CLK_DIV);
      irq_en <= 1'b0;
      irq_o <= 1'b0;
      data_o <= '0;
    end else begin
      if (wr && addr_i[3:2] == 2'd2) div <= data_i[15:0] == 16'd0 ? 16'd1 : data_i[15:0];
      if (wr && addr_i[3:2] == 2'd3) irq_en <= data_i[0];
      irq_o <= irq_en & empty;
      if (rd) data_o <= rdata;
    end
  end
endmodule

// File: tb/tb_uart_tx_periph.sv
// tb_uart_tx_periph: randomized bench checking the UART line and registers against a frame-timeline model
module tb_uart_tx_periph;
  logic clk = 0, reset = 1, enable_i = 0;
  logic [3:0] we_i = 0;
  logic [31:0] addr_i = 0, data_i = 0, data_o, d;
  logic tx_o, irq_o;
  int cyc = 0, checks = 0, errors = 0, last_end = 0, mdiv = 868;
  bit movf = 0, men = 0, mon = 0;
  typedef struct {int a; int s; int d; logic [7:0] b;} frame_t;
  frame_t fq[$];
  uart_tx_periph #(.FIFO_DEPTH(16), .CLK_DIV(868)) dut (
    .clk(clk), .reset(reset), .enable_i(enable_i), .we_i(we_i), .addr_i(addr_i),
    .data_i(data_i), .data_o(data_o), .tx_o(tx_o), .irq_o(irq_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  // Each accepted byte is a frame: accepted at edge a, popped at edge s-1, on the line for cycles [s, s+10d)
  function automatic int cnt_before(int t);
    int n = 0;
    foreach (fq[i]) if (fq[i].a < t && t <= fq[i].s - 1) n++;
    return n;
  endfunction
  function automatic bit pop_at(int t);
    foreach (fq[i]) if (fq[i].s - 1 == t) return 1;
    return 0;
  endfunction
  function automatic bit busy_before(int t);
    foreach (fq[i]) if (t - 1 >= fq[i].s - 1 && t - 1 <= fq[i].s + 10 * fq[i].d - 2) return 1;
    return 0;
  endfunction
  function automatic logic exp_tx(int t);
    foreach (fq[i])
      if (t >= fq[i].s && t < fq[i].s + 10 * fq[i].d) begin
        int k = (t - fq[i].s) / fq[i].d;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return fq[i].b[k-1];
      end
    return 1'b1;
  endfunction
  function automatic logic [31:0] status_exp(int t);
    int n = cnt_before(t);
    return {16'd0, 8'(n), 4'd0, movf, busy_before(t), n == 16, n == 0};
  endfunction
  task automatic model_push(int n, logic [7:0] b);
    frame_t f;
    if (cnt_before(n) < 16 || pop_at(n)) begin
      f.a = n;
      f.s = (n + 2 > last_end) ? n + 2 : last_end;
      f.d = mdiv;
      f.b = b;
      fq.push_back(f);
      last_end = f.s + 10 * f.d;
    end else movf = 1;
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    enable_i = 1;
    we_i = 4'($urandom_range(1, 15));
    addr_i = ($urandom() & 32'hFFFF_FFF3) | {28'd0, a, 2'b00};
    data_i = v;
    @(posedge clk);
    #1;
    enable_i = 0;
    we_i = 0;
    case (a)
      2'd0: model_push(cyc, v[7:0]);
      2'd1: if (v[3]) movf = 0;
      2'd2: mdiv = v[15:0] == 16'd0 ? 1 : int'(v[15:0]);
      default: men = v[0];
    endcase
  endtask
  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    enable_i = 1;
    we_i = 0;
    addr_i = ($urandom() & 32'hFFFF_FFF3) | {28'd0, a, 2'b00};
    @(posedge clk);
    #1;
    enable_i = 0;
    v = data_o;
  endtask
  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_until(int t);
    while (cyc < t) @(posedge clk);
    #1;
  endtask
  task automatic chk_status(string tag);
    logic [31:0] v;
    rd(2'd1, v);
    check(tag, v, status_exp(cyc));
  endtask
  always @(negedge clk) if (mon) check("tx_line", 32'(tx_o), 32'(exp_tx(cyc)));
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", 32'(tx_o), 32'd1);
    check("rst_data", data_o, 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    reset = 0;
    mon = 1;
    idle(100);
    rd(2'd1, d);
    check("idle_status", d, 32'h1);
    check("idle_irq", 32'(irq_o), 32'd0);
    rd(2'd2, d);
    check("div_reset", d, 32'd868);
    rd(2'd3, d);
    check("ctrl_reset", d, 32'd0);
    wr(2'd2, 32'd4);
    wr(2'd0, {$urandom_range(0, 16'hFFFF), 16'h00A5});
    idle(10);
    wr(2'd2, 32'd3);
    rd(2'd0, d);
    check("txdata_read", d, 32'd0);
    wait_until(last_end + 2);
    rd(2'd1, d);
    check("a5_done", d, 32'h1);
    wr(2'd2, 32'd2);
    rd(2'd2, d);
    idle(3);
    check("read_hold", data_o, 32'd2);
    wr(2'd0, 32'h00);
    wr(2'd0, 32'hFF);
    wr(2'd0, 32'h55);
    rd(2'd1, d);
    check("b2b_count", 32'(d[15:8]), 32'd2);
    check("b2b_status", d, status_exp(cyc));
    wait_until(last_end + 2);
    chk_status("b2b_done");
    for (int r = 0; r < 8; r++) begin
      wr(2'd2, 32'($urandom_range(0, 5)));
      rd(2'd2, d);
      check("div_read", d, 32'(mdiv));
      for (int j = 0; j < int'($urandom_range(1, 6)); j++) begin
        wr(2'd0, $urandom());
        idle($urandom_range(0, 3));
        if (j == 1) chk_status("rand_status");
      end
      wait_until(last_end + 2);
      chk_status("rand_done");
    end
    wr(2'd3, 32'd1);
    check("irq_lag", 32'(irq_o), 32'd0);
    idle(1);
    check("irq_on", 32'(irq_o), 32'd1);
    wr(2'd0, $urandom());
    check("irq_push0", 32'(irq_o), 32'd1);
    idle(1);
    check("irq_drop", 32'(irq_o), 32'd0);
    idle(1);
    check("irq_rise", 32'(irq_o), 32'd1);
    rd(2'd3, d);
    check("ctrl_read", d, 32'd1);
    wait_until(last_end + 2);
    check("irq_end", 32'(irq_o), 32'd1);
    wr(2'd3, 32'd0);
    idle(1);
    check("irq_off", 32'(irq_o), 32'd0);
    wr(2'd2, 32'd1000);
    for (int j = 0; j < 18; j++) wr(2'd0, $urandom());
    rd(2'd1, d);
    check("ovf_status", d, 32'h100E);
    check("ovf_model", d, status_exp(cyc));
    wr(2'd1, $urandom() | 32'h8);
    rd(2'd1, d);
    check("ovf_clear", d, 32'h1006);
    check("ovf_clr_model", d, status_exp(cyc));
    wait_until(fq[fq.size() - 17].s + 3500);
    check("pre_rst_tx", 32'(tx_o), 32'(exp_tx(cyc)));
    reset = 1;
    fq.delete();
    last_end = 0;
    movf = 0;
    mdiv = 868;
    men = 0;
    #1;
    check("rst_mid_tx", 32'(tx_o), 32'd1);
    idle(2);
    reset = 0;
    rd(2'd1, d);
    check("post_rst_status", d, 32'h1);
    rd(2'd2, d);
    check("post_rst_div", d, 32'd868);
    wr(2'd0, $urandom());
    wait_until(last_end + 2);
    chk_status("post_rst_done");
    mon = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_periph.md
# uart_tx_periph

Memory-mapped UART transmitter with a byte FIFO. It sits on the RS5 data bus next to the RAM, RTC, PLIC and plugin decodes, and consumes the CPU's character writes. It serialises them as 8N1 frames on `tx_o`, so program output leaves the chip on a real serial line rather than through a simulation-only output register. Reads use the same registered-response timing as the other peripherals, so the existing one-cycle read-mux pattern applies unchanged.

## Interface
- `FIFO_DEPTH`, default 16: TX FIFO entries; must be a power of two, at least 2.
- `CLK_DIV`, default 868: reset value of the DIVISOR register (100 MHz clock, 115200 baud).
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  reset; asynchronous, active-high.
- `enable_i`  in  1  peripheral selected this cycle (from the address decode).
- `we_i`  in  4  byte write enables; any nonzero value is a write, zero is a read.
- `addr_i`  in  32  bus address; only `addr_i[3:2]` is decoded.
- `data_i`  in  32  write data.
- `data_o`  out  32  registered read data.
- `tx_o`  out  1  serial output; idles high.
- `irq_o`  out  1  level interrupt: TX FIFO empty and interrupt enabled.

## Operation
- Register map (offset, selected by `addr_i[3:2]`):
  - 0x0 TXDATA, write-only: a write pushes `data_i[7:0]`; reads return 0.
  - 0x4 STATUS, read: bit0 empty, bit1 full, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[15:8] FIFO count, other bits 0. Writing 1 to bit3 clears overflow; all other bits are ignored.
  - 0x8 DIVISOR, read/write: bits[15:0] give bit period in clocks; writing 0 stores 1.
  - 0xC CTRL, read/write: bit0 irq_en, reset 0.
- Push to a full FIFO: the byte is dropped and overflow is set. Exception: a pop in the same cycle makes the push accepted, with count unchanged.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, latch DIVISOR into the bit timer, and go to START.
  - START: `tx_o`=0 for DIV cycles, then go to DATA with the bit index at 0.
  - DATA: `tx_o`=shift[0] for DIV cycles per bit, LSB first; after bit 7 go to STOP.
  - STOP: `tx_o`=1 for DIV cycles. At the end, if the FIFO is non-empty, pop and go straight to START with no idle gap; otherwise go to IDLE.
- DIVISOR writes during a frame do not affect that frame; the new value applies from the next START entry.
- Bit timer: a 16-bit down-counter loaded with DIV-1 at each bit start. The bit ends when the counter reaches 0.
- FIFO: circular buffer with read/write pointers of log2(FIFO_DEPTH) bits that wrap modulo depth. The count is log2(FIFO_DEPTH)+1 bits.
- `irq_o` = irq_en & empty, registered.

## Timing
- Reset values:
  - `tx_o`=1, `data_o`=0, `irq_o`=0.
  - FIFO empty, pointers 0, overflow 0.
  - DIVISOR=CLK_DIV, CTRL=0, FSM IDLE.
- Reset asserted mid-frame: `tx_o` goes to 1 immediately (asynchronously), the FIFO is flushed, and the frame is abandoned.
- Write at edge N: the FIFO count is updated after edge N. IDLE sees non-empty at edge N+1 and pops. `tx_o` falls after edge N+2.
- Frame length is exactly 10*DIV cycles.
- Back-to-back bytes: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- Read at edge N (`enable_i`=1, `we_i`=0): `data_o` is valid after edge N and holds until the next read. STATUS reflects state before edge N.
- Pop and STATUS read in the same cycle: the read returns the pre-pop count.
- `irq_o` lags the empty condition by one cycle.

## Test plan
- Reset, then idle for 100 cycles: `tx_o`=1, STATUS read = 0x00000001, `irq_o`=0.
- DIVISOR=4; write 0xA5 to TXDATA. `tx_o` shows 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles. Total 40 cycles; busy clears afterwards.
- DIVISOR=2; write 3 bytes 0x00, 0xFF, 0x55 back-to-back. Result: 60 contiguous cycles of framing with no idle-high gap beyond the stop bits. STATUS count reads 2 immediately after the first pop.
- DIVISOR=1000; write 18 bytes with FIFO_DEPTH=16:
  - One byte is popped, 16 are stored, 1 is dropped.
  - STATUS = full | busy | overflow | count 16 (0x0000100E).
  - Writing 0x8 to STATUS clears overflow.
- CTRL=1 with the FIFO empty: `irq_o`=1 one cycle later. Push a byte: `irq_o` drops one cycle after the count becomes 1, then rises again after the byte is popped.
- Assert `reset` mid data bit: `tx_o`=1 in the same cycle and count=0. After release, the next write produces a clean frame using DIVISOR=868.
